shift_sequencer: RTL

SHIFT_SEQUENCER -- requirements
Module: shift_sequencer

---
 rtl/shift_sequencer_pkg.sv | 10 +
 rtl/shift_sequencer_shift_step.sv | 37 +++
 rtl/shift_sequencer.sv | 79 +++++++
 3 files changed

// File: rtl/shift_sequencer_pkg.sv
// Shared types and constants for the multi-cycle shift/rotate sequencer.
package shift_sequencer_pkg;
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int unsigned MAX_STEP = 3;
endpackage

// File: rtl/shift_sequencer_shift_step.sv
// One combinational shift/rotate step of 0..3 positions, built from 4-bit slices.
module shift_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] data,
  input  logic [1:0]       step,
  input  logic             rotate,
  output logic [WIDTH-1:0] result
);
  localparam int SLICES = WIDTH / 4;

  for (genvar g = 0; g < SLICES; g++) begin : g_slice
    logic [2:0] cin;
    logic [6:0] ext;
    logic [3:0] o;

    // Lowest slice takes the wrapped word MSBs on rotate, zeros otherwise.
    if (g == 0) begin : g_low
      assign cin = rotate ? data[WIDTH-1 -: 3] : 3'b000;
    end else begin : g_mid
      assign cin = data[4*g-1 -: 3];
    end

    assign ext = {data[4*g +: 4], cin};

    always_comb begin
      case (step)
        2'd0:    o = ext[6:3];
        2'd1:    o = ext[5:2];
        2'd2:    o = ext[4:1];
        default: o = ext[3:0];
      endcase
    end

    assign result[4*g +: 4] = o;
  end
endmodule

// File: rtl/shift_sequencer.sv
// Sequencer applying a shift/rotate of up to WIDTH-1 positions in steps of at most 3.
module shift_sequencer
  import shift_sequencer_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int AW    = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             mode,
  input  logic [AW-1:0]    amount,
  input  logic [WIDTH-1:0] din,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] dout
);
  state_t           state, state_next;
  logic [WIDTH-1:0] data, data_next, shifted;
  logic [AW-1:0]    rem, rem_next;
  logic             md;
  logic [1:0]       step;

  assign step = (rem > AW'(MAX_STEP)) ? 2'(MAX_STEP) : rem[1:0];

  shift_step #(.WIDTH(WIDTH)) u_step (
    .data   (data),
    .step   (step),
    .rotate (md),
    .result (shifted)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      data  <= '0;
      rem   <= '0;
      md    <= 1'b0;
      dout  <= '0;
    end else begin
      state <= state_next;
      data  <= data_next;
      rem   <= rem_next;
      if (state == IDLE && start)
        md <= mode;
      // dout is loaded on entry to DONE so it is valid together with done.
      if (state_next == DONE)
        dout <= data_next;
    end
  end

  always_comb begin
    state_next = state;
    data_next  = data;
    rem_next   = rem;
    case (state)
      IDLE: begin
        if (start) begin
          data_next  = din;
          rem_next   = amount;
          state_next = (amount == '0) ? DONE : SHIFT;
        end
      end
      SHIFT: begin
        data_next = shifted;
        rem_next  = rem - AW'(step);
        if (rem == AW'(step))
          state_next = DONE;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy = (state != IDLE);
    done = (state == DONE);
  end
endmodule
